// File: rtl/tl_pkg.sv
// Shared TileLink-UL types for the SRAM responder: channel opcodes, atomic params,
// responder FSM states and the burst beat-count helper.
package tl_pkg;

    typedef enum logic [2:0] {
        A_PUT_FULL    = 3'd0,
        A_PUT_PARTIAL = 3'd1,
        A_ARITH       = 3'd2,
        A_LOGIC       = 3'd3,
        A_GET         = 3'd4
    } a_op_e;

    typedef enum logic [2:0] {
        D_ACCESS_ACK      = 3'd0,
        D_ACCESS_ACK_DATA = 3'd1
    } d_op_e;

    typedef enum logic [2:0] {
        ARITH_MIN  = 3'd0,
        ARITH_MAX  = 3'd1,
        ARITH_MINU = 3'd2,
        ARITH_MAXU = 3'd3,
        ARITH_ADD  = 3'd4
    } arith_e;

    typedef enum logic [2:0] {
        LOGIC_XOR  = 3'd0,
        LOGIC_OR   = 3'd1,
        LOGIC_AND  = 3'd2,
        LOGIC_SWAP = 3'd3
    } logic_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WRITE,
        ST_READ,
        ST_ACK,
        ST_RMW
    } state_e;

    // Oversized requests are clamped to the largest legal burst length.
    function automatic int beat_count(input int size, input int lb, input int max_size);
        int eff;
        eff = (size > max_size) ? max_size : size;
        return (eff <= lb) ? 1 : (1 << (eff - lb));
    endfunction

endpackage

// File: rtl/tl_sram_mem.sv
// Single-port synchronous RAM with per-byte write enables; the read register
// keeps its value on any cycle without a read.
module tl_sram_mem #(
    parameter int DW    = 32,
    parameter int DEPTH = 1024,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            en,
    input  logic            we,
    input  logic [AW-1:0]   addr,
    input  logic [DW/8-1:0] be,
    input  logic [DW-1:0]   wdata,
    output logic [DW-1:0]   rdata
);

    logic [DW-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                for (int i = 0; i < DW/8; i++) begin
                    if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
                end
            end else begin
                rdata <= mem[addr];
            end
        end
    end

endmodule

// File: rtl/tl_ul_sram_responder.sv
// TileLink-UL slave endpoint in front of a single-port SRAM.
// Define TL_SRAM_ATOMIC_EN to add single-beat ArithmeticData/LogicalData support.
//
// state    | meaning
// ST_IDLE  | waiting for the first A beat
// ST_WRITE | collecting remaining Put beats
// ST_READ  | returning AccessAckData beats
// ST_ACK   | returning the single AccessAck
// ST_RMW   | atomic: old data read, writing the result
module tl_ul_sram_responder
    import tl_pkg::*;
#(
    parameter int               TL_DW       = 32,
    parameter int               TL_AW       = 32,
    parameter int               TL_RS       = 5,
    parameter int               TL_SZ       = 4,
    parameter logic [TL_AW-1:0] BASE_ADDR   = 32'h0000_1000,
    parameter int               DEPTH_WORDS = 1024,
    parameter int               MAX_SIZE    = 6
) (
    input  logic               tilelink_clock_i,
    input  logic               tilelink_reset_ni,
    input  logic [2:0]         slave_a_opcode,
    input  logic [2:0]         slave_a_param,
    input  logic [TL_SZ-1:0]   slave_a_size,
    input  logic [TL_RS-1:0]   slave_a_source,
    input  logic [TL_AW-1:0]   slave_a_address,
    input  logic [TL_DW/8-1:0] slave_a_mask,
    input  logic [TL_DW-1:0]   slave_a_data,
    input  logic               slave_a_corrupt,
    input  logic               slave_a_valid,
    output logic               slave_a_ready,
    output logic [2:0]         slave_d_opcode,
    output logic [1:0]         slave_d_param,
    output logic [TL_SZ-1:0]   slave_d_size,
    output logic [TL_RS-1:0]   slave_d_source,
    output logic               slave_d_denied,
    output logic [TL_DW-1:0]   slave_d_data,
    output logic               slave_d_corrupt,
    output logic               slave_d_valid,
    input  logic               slave_d_ready
);

    localparam int LB = $clog2(TL_DW/8);
    localparam int MW = $clog2(DEPTH_WORDS);
    localparam int CW = MAX_SIZE + 2;
    localparam logic [TL_AW:0] MEM_BYTES = (TL_AW+1)'(DEPTH_WORDS * (TL_DW/8));

    state_e              state_q, state_d;
    logic [CW-1:0]       beat_q, beats_q, a_beats;
    logic [MW-1:0]       word_q, a_word;
    logic [TL_RS-1:0]    source_q;
    logic [TL_SZ-1:0]    size_q;
    d_op_e               op_q;
    logic                legal_q, denied_q, corrupt_q, put_full_q;
    logic [TL_AW-1:0]    off;
    logic [TL_AW:0]      size_bytes;
    logic                addr_ok, last;
    logic                mem_en, mem_we;
    logic [MW-1:0]       mem_addr;
    logic [TL_DW/8-1:0]  mem_be;
    logic [TL_DW-1:0]    mem_wdata, mem_rdata;

    // Legality of the first beat: in range, aligned, whole burst fits, size allowed.
    assign off        = slave_a_address - BASE_ADDR;
    assign size_bytes = (TL_AW+1)'(1) << slave_a_size;
    assign addr_ok    = (slave_a_size <= TL_SZ'(MAX_SIZE))
                      && ((slave_a_address & ~({TL_AW{1'b1}} << slave_a_size)) == '0)
                      && (slave_a_address >= BASE_ADDR)
                      && (({1'b0, off} + size_bytes) <= MEM_BYTES);
    assign a_word     = off[LB +: MW];
    assign a_beats    = CW'(beat_count(int'(slave_a_size), LB, MAX_SIZE));
    assign last       = (beat_q == beats_q - CW'(1));

`ifdef TL_SRAM_ATOMIC_EN
    logic [2:0]         param_q;
    logic               logic_q;
    logic [TL_DW/8-1:0] mask_q;
    logic [TL_DW-1:0]   adata_q, bmask, opa, opb, alu_res;
    logic               atomic_ok;

    assign atomic_ok = addr_ok && (a_beats == CW'(1))
                     && ((slave_a_opcode == A_ARITH) ? (slave_a_param <= 3'd4)
                                                     : (slave_a_param <= 3'd3));

    // Signed MIN/MAX compare the whole masked word, so they are exact for word-sized operands.
    always_comb begin
        bmask = '0;
        for (int i = 0; i < TL_DW/8; i++) bmask[8*i +: 8] = {8{mask_q[i]}};
        opa     = mem_rdata & bmask;
        opb     = adata_q & bmask;
        alu_res = opb;
        if (!logic_q) begin
            case (param_q)
                ARITH_MIN:  alu_res = ($signed(opa) < $signed(opb)) ? opa : opb;
                ARITH_MAX:  alu_res = ($signed(opa) > $signed(opb)) ? opa : opb;
                ARITH_MINU: alu_res = (opa < opb) ? opa : opb;
                ARITH_MAXU: alu_res = (opa > opb) ? opa : opb;
                ARITH_ADD:  alu_res = opa + opb;
                default:    alu_res = opb;
            endcase
        end else begin
            case (param_q)
                LOGIC_XOR:  alu_res = opa ^ opb;
                LOGIC_OR:   alu_res = opa | opb;
                LOGIC_AND:  alu_res = opa & opb;
                default:    alu_res = opb;
            endcase
        end
    end
`else
    logic unused_param;
    assign unused_param = ^slave_a_param;
`endif

    always_ff @(posedge tilelink_clock_i or negedge tilelink_reset_ni) begin
        if (!tilelink_reset_ni) state_q <= ST_IDLE;
        else                    state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = a_word;
        mem_be    = '0;
        mem_wdata = slave_a_data;
        case (state_q)
            ST_IDLE: if (slave_a_valid) begin
                case (slave_a_opcode)
                    A_GET: begin
                        state_d = ST_READ;
                        mem_en  = addr_ok;
                    end
                    A_PUT_FULL, A_PUT_PARTIAL: begin
                        state_d = (a_beats == CW'(1)) ? ST_ACK : ST_WRITE;
                        mem_en  = addr_ok && !slave_a_corrupt;
                        mem_we  = 1'b1;
                        mem_be  = (slave_a_opcode == A_PUT_FULL) ? '1 : slave_a_mask;
                    end
                    A_ARITH, A_LOGIC: begin
`ifdef TL_SRAM_ATOMIC_EN
                        state_d = atomic_ok ? ST_RMW : ST_READ;
                        mem_en  = atomic_ok;
`else
                        state_d = ST_ACK;
`endif
                    end
                    default: state_d = ST_ACK;
                endcase
            end
            ST_WRITE: if (slave_a_valid) begin
                mem_en   = legal_q && !slave_a_corrupt;
                mem_we   = 1'b1;
                mem_addr = word_q + MW'(beat_q);
                mem_be   = put_full_q ? '1 : slave_a_mask;
                if (last) state_d = ST_ACK;
            end
            ST_ACK: if (slave_d_ready) state_d = ST_IDLE;
            ST_READ: if (slave_d_ready) begin
                if (last) begin
                    state_d = ST_IDLE;
                end else begin
                    mem_en   = legal_q;
                    mem_addr = word_q + MW'(beat_q + CW'(1));
                end
            end
`ifdef TL_SRAM_ATOMIC_EN
            ST_RMW: begin
                state_d   = ST_READ;
                mem_en    = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = word_q;
                mem_be    = mask_q;
                mem_wdata = alu_res;
            end
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge tilelink_clock_i or negedge tilelink_reset_ni) begin
        if (!tilelink_reset_ni) begin
            beat_q     <= '0;
            beats_q    <= '0;
            word_q     <= '0;
            source_q   <= '0;
            size_q     <= '0;
            op_q       <= D_ACCESS_ACK;
            legal_q    <= 1'b0;
            denied_q   <= 1'b0;
            corrupt_q  <= 1'b0;
            put_full_q <= 1'b0;
`ifdef TL_SRAM_ATOMIC_EN
            param_q    <= '0;
            logic_q    <= 1'b0;
            mask_q     <= '0;
            adata_q    <= '0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: if (slave_a_valid) begin
                    source_q   <= slave_a_source;
                    size_q     <= slave_a_size;
                    word_q     <= a_word;
                    beats_q    <= a_beats;
                    beat_q     <= '0;
                    put_full_q <= (slave_a_opcode == A_PUT_FULL);
                    case (slave_a_opcode)
                        A_GET: begin
                            op_q      <= D_ACCESS_ACK_DATA;
                            legal_q   <= addr_ok;
                            denied_q  <= !addr_ok;
                            corrupt_q <= !addr_ok;
                        end
                        A_PUT_FULL, A_PUT_PARTIAL: begin
                            op_q      <= D_ACCESS_ACK;
                            legal_q   <= addr_ok;
                            denied_q  <= !addr_ok || slave_a_corrupt;
                            corrupt_q <= 1'b0;
                            beat_q    <= CW'(1);
                        end
                        A_ARITH, A_LOGIC: begin
                            op_q      <= D_ACCESS_ACK_DATA;
`ifdef TL_SRAM_ATOMIC_EN
                            legal_q   <= atomic_ok;
                            denied_q  <= !atomic_ok;
                            corrupt_q <= !atomic_ok;
                            param_q   <= slave_a_param;
                            logic_q   <= (slave_a_opcode == A_LOGIC);
                            mask_q    <= slave_a_mask;
                            adata_q   <= slave_a_data;
`else
                            legal_q   <= 1'b0;
                            denied_q  <= 1'b1;
                            corrupt_q <= 1'b1;
`endif
                        end
                        default: begin
                            op_q      <= D_ACCESS_ACK;
                            legal_q   <= 1'b0;
                            denied_q  <= 1'b1;
                            corrupt_q <= 1'b0;
                        end
                    endcase
                end
                ST_WRITE: if (slave_a_valid) begin
                    beat_q <= beat_q + CW'(1);
                    if (slave_a_corrupt) denied_q <= 1'b1;
                end
                ST_READ: if (slave_d_ready && !last) beat_q <= beat_q + CW'(1);
                default: ;
            endcase
        end
    end

    tl_sram_mem #(.DW(TL_DW), .DEPTH(DEPTH_WORDS), .AW(MW)) u_mem (
        .clk   (tilelink_clock_i),
        .en    (mem_en),
        .we    (mem_we),
        .addr  (mem_addr),
        .be    (mem_be),
        .wdata (mem_wdata),
        .rdata (mem_rdata)
    );

    assign slave_a_ready   = (state_q == ST_IDLE) || (state_q == ST_WRITE);
    assign slave_d_valid   = (state_q == ST_READ) || (state_q == ST_ACK);
    assign slave_d_opcode  = op_q;
    assign slave_d_param   = 2'b00;
    assign slave_d_size    = size_q;
    assign slave_d_source  = source_q;
    assign slave_d_denied  = slave_d_valid && denied_q;
    assign slave_d_corrupt = slave_d_valid && corrupt_q;
    assign slave_d_data    = ((state_q == ST_READ) && !corrupt_q) ? mem_rdata : '0;

endmodule

// File: tb/tb_tl_ul_sram_responder.sv
// Directed bench for tl_ul_sram_responder; expectations switch on TL_SRAM_ATOMIC_EN.
module tb_tl_ul_sram_responder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  a_opcode, a_param;
    logic [3:0]  a_size;
    logic [4:0]  a_source;
    logic [31:0] a_address;
    logic [3:0]  a_mask;
    logic [31:0] a_data;
    logic        a_corrupt, a_valid, a_ready;
    logic [2:0]  d_opcode;
    logic [1:0]  d_param;
    logic [3:0]  d_size;
    logic [4:0]  d_source;
    logic        d_denied, d_corrupt, d_valid, d_ready;
    logic [31:0] d_data;

    logic [2:0]  r_opcode;
    logic [3:0]  r_size;
    logic [4:0]  r_source;
    logic        r_denied, r_corrupt;
    logic [31:0] r_data;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    tl_ul_sram_responder dut (
        .tilelink_clock_i  (clk),
        .tilelink_reset_ni (rst_n),
        .slave_a_opcode    (a_opcode),
        .slave_a_param     (a_param),
        .slave_a_size      (a_size),
        .slave_a_source    (a_source),
        .slave_a_address   (a_address),
        .slave_a_mask      (a_mask),
        .slave_a_data      (a_data),
        .slave_a_corrupt   (a_corrupt),
        .slave_a_valid     (a_valid),
        .slave_a_ready     (a_ready),
        .slave_d_opcode    (d_opcode),
        .slave_d_param     (d_param),
        .slave_d_size      (d_size),
        .slave_d_source    (d_source),
        .slave_d_denied    (d_denied),
        .slave_d_data      (d_data),
        .slave_d_corrupt   (d_corrupt),
        .slave_d_valid     (d_valid),
        .slave_d_ready     (d_ready)
    );

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_a(input logic [2:0] op, input logic [2:0] prm, input logic [3:0] sz,
                          input logic [4:0] src, input logic [31:0] addr, input logic [3:0] msk,
                          input logic [31:0] dat, input logic crp);
        int n = 0;
        a_opcode = op; a_param = prm; a_size = sz; a_source = src;
        a_address = addr; a_mask = msk; a_data = dat; a_corrupt = crp;
        a_valid = 1'b1;
        while (!a_ready && n < 50) begin
            tick();
            n++;
        end
        if (!a_ready) check_eq("a_ready_wait", a_ready, 1);
        tick();
        a_valid = 1'b0;
        a_corrupt = 1'b0;
    endtask

    task automatic recv_d();
        int n = 0;
        d_ready = 1'b1;
        while (!d_valid && n < 50) begin
            tick();
            n++;
        end
        if (!d_valid) check_eq("d_valid_wait", d_valid, 1);
        r_opcode = d_opcode; r_size = d_size; r_source = d_source;
        r_denied = d_denied; r_corrupt = d_corrupt; r_data = d_data;
        tick();
        d_ready = 1'b0;
    endtask

    task automatic put_word(input logic [31:0] addr, input logic [31:0] dat);
        send_a(3'd0, 3'd0, 4'd2, 5'd1, addr, 4'hF, dat, 1'b0);
        recv_d();
    endtask

    task automatic get_word(input string tag, input logic [31:0] addr, input logic [31:0] exp);
        send_a(3'd4, 3'd0, 4'd2, 5'd9, addr, 4'hF, 32'h0, 1'b0);
        recv_d();
        check_eq(tag, r_data, exp);
    endtask

    logic pat [6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

    initial begin
        int k;
        int cnt;
        rst_n = 1'b0; a_valid = 1'b0; d_ready = 1'b0; a_corrupt = 1'b0;
        a_opcode = '0; a_param = '0; a_size = '0; a_source = '0;
        a_address = '0; a_mask = '0; a_data = '0;
        #12;
        check_eq("rst_a_ready", a_ready, 1);
        check_eq("rst_d_valid", d_valid, 0);
        check_eq("rst_d_opcode", d_opcode, 0);
        check_eq("rst_d_denied", d_denied, 0);
        check_eq("rst_d_corrupt", d_corrupt, 0);
        check_eq("rst_d_data", d_data, 0);
        tick();
        rst_n = 1'b1;
        tick();

        // Put then Get with latency and echo checks
        send_a(3'd0, 3'd0, 4'd2, 5'd2, 32'h1004, 4'hF, 32'hDEADBEEF, 1'b0);
        check_eq("put_lat", d_valid, 1);
        recv_d();
        check_eq("put_opcode", r_opcode, 0);
        check_eq("put_denied", r_denied, 0);
        check_eq("put_source", r_source, 2);
        check_eq("put_size", r_size, 2);
        send_a(3'd4, 3'd0, 4'd2, 5'd7, 32'h1004, 4'hF, 32'h0, 1'b0);
        check_eq("get_lat", d_valid, 1);
        recv_d();
        check_eq("get_data", r_data, 32'hDEADBEEF);
        check_eq("get_opcode", r_opcode, 1);
        check_eq("get_source", r_source, 7);
        check_eq("get_denied", r_denied, 0);
        check_eq("get_corrupt", r_corrupt, 0);
        check_eq("get_next_ready", a_ready, 1);

        // PutPartial merges one byte lane
        put_word(32'h1008, 32'h11223344);
        send_a(3'd1, 3'd0, 4'd2, 5'd1, 32'h1008, 4'b0010, 32'h0000AB00, 1'b0);
        recv_d();
        check_eq("partial_ack", r_denied, 0);
        get_word("partial_data", 32'h1008, 32'h1122AB44);

        // 4-beat PutFull then 4-beat Get with stalls
        for (int i = 0; i < 4; i++) send_a(3'd0, 3'd0, 4'd4, 5'd1, 32'h1010, 4'hF, 32'(i + 1), 1'b0);
        check_eq("burst_put_lat", d_valid, 1);
        recv_d();
        check_eq("burst_put_opcode", r_opcode, 0);
        check_eq("burst_put_size", r_size, 4);
        check_eq("burst_put_ready", a_ready, 1);
        send_a(3'd4, 3'd0, 4'd4, 5'd3, 32'h1010, 4'hF, 32'h0, 1'b0);
        k = 0;
        for (int i = 0; i < 6; i++) begin
            d_ready = pat[i];
            check_eq("burst_valid", d_valid, 1);
            check_eq($sformatf("burst_data%0d", k), d_data, 64'(k + 1));
            if (pat[i]) k++;
            tick();
        end
        d_ready = 1'b0;
        check_eq("burst_done", d_valid, 0);

        // Out-of-range Get and misaligned Put
        send_a(3'd4, 3'd0, 4'd2, 5'd4, 32'h2000, 4'hF, 32'h0, 1'b0);
        recv_d();
        check_eq("oor_denied", r_denied, 1);
        check_eq("oor_corrupt", r_corrupt, 1);
        check_eq("oor_data", r_data, 0);
        check_eq("oor_opcode", r_opcode, 1);
        put_word(32'h1000, 32'h01020304);
        send_a(3'd0, 3'd0, 4'd2, 5'd6, 32'h1002, 4'hF, 32'hFFFFFFFF, 1'b0);
        recv_d();
        check_eq("misalign_denied", r_denied, 1);
        check_eq("misalign_opcode", r_opcode, 0);
        get_word("misalign_mem", 32'h1000, 32'h01020304);

        // Unsupported opcode
        send_a(3'd5, 3'd0, 4'd2, 5'd8, 32'h1000, 4'hF, 32'h0, 1'b0);
        recv_d();
        check_eq("op5_denied", r_denied, 1);
        check_eq("op5_opcode", r_opcode, 0);
        check_eq("op5_corrupt", r_corrupt, 0);

        // Atomic ADD 5 to 10
        put_word(32'h1020, 32'd10);
        send_a(3'd2, 3'd4, 4'd2, 5'd11, 32'h1020, 4'hF, 32'd5, 1'b0);
        recv_d();
        check_eq("atomic_opcode", r_opcode, 1);
        check_eq("atomic_source", r_source, 11);
`ifdef TL_SRAM_ATOMIC_EN
        check_eq("atomic_denied", r_denied, 0);
        check_eq("atomic_old", r_data, 10);
        get_word("atomic_new", 32'h1020, 32'd15);
`else
        check_eq("atomic_denied", r_denied, 1);
        check_eq("atomic_corrupt", r_corrupt, 1);
        check_eq("atomic_data", r_data, 0);
        get_word("atomic_mem", 32'h1020, 32'd10);
`endif

        // Oversized Get: denied, beat count clamped to 16
        send_a(3'd4, 3'd0, 4'd7, 5'd5, 32'h1000, 4'hF, 32'h0, 1'b0);
        check_eq("oversize_corrupt", d_corrupt, 1);
        check_eq("oversize_denied", d_denied, 1);
        d_ready = 1'b1;
        cnt = 0;
        while (d_valid && cnt < 40) begin
            cnt++;
            tick();
        end
        d_ready = 1'b0;
        check_eq("oversize_beats", cnt, 16);

        // Corrupt second beat is dropped and the ack is denied
        put_word(32'h1034, 32'h00000055);
        send_a(3'd0, 3'd0, 4'd3, 5'd1, 32'h1030, 4'hF, 32'hA0A0A0A0, 1'b0);
        send_a(3'd0, 3'd0, 4'd3, 5'd1, 32'h1030, 4'hF, 32'hBBBBBBBB, 1'b1);
        recv_d();
        check_eq("crp_ack_denied", r_denied, 1);
        send_a(3'd4, 3'd0, 4'd3, 5'd1, 32'h1030, 4'hF, 32'h0, 1'b0);
        d_ready = 1'b1;
        check_eq("crp_beat0", d_data, 32'hA0A0A0A0);
        tick();
        check_eq("crp_beat1", d_data, 32'h00000055);
        tick();
        d_ready = 1'b0;

        // Reset during beat 2 of a 4-beat Get
        send_a(3'd4, 3'd0, 4'd4, 5'd3, 32'h1010, 4'hF, 32'h0, 1'b0);
        d_ready = 1'b1;
        tick();
        tick();
        check_eq("rst_burst_beat2", d_data, 3);
        rst_n = 1'b0;
        #1;
        check_eq("rst_burst_dvalid", d_valid, 0);
        check_eq("rst_burst_aready", a_ready, 1);
        d_ready = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        get_word("after_rst_get", 32'h1004, 32'hDEADBEEF);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
